// File: rtl/stream_demux_1_n_pkg.sv
// Shared constants and helpers for the 1:N stream demultiplexer.
// The select width is derived here so the interface and the top always agree on it.
package stream_demux_pkg;

   localparam int MAX_CHANNELS = 64;

   // ceil(log2(n)), but never narrower than one bit
   function automatic int sel_width(int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_demux_1_n_if.sv
// Bus bundle between one stream producer and the demux, plus the N consumer-side channels.
// The master modport is the environment (producer and consumers); the slave modport is the demux.
interface stream_demux_1_n_if
   import stream_demux_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 8
);

   localparam int SEL_WIDTH = sel_width(NUM_CHANNELS);

   // Handshake: a word moves when valid and ready are both high at a rising edge.
   // Valid must hold its word until it moves. Ready may rise or fall freely and
   // never looks at valid.
   logic                                 Enable_In;
   logic                                 Broadcast_In;
   logic                                 Valid_In;
   logic                                 Ready_Out;
   logic [DATA_WIDTH-1:0]                Data_In;
   logic [SEL_WIDTH-1:0]                 Select_In;
   logic [NUM_CHANNELS-1:0]              Valid_Out;
   logic [NUM_CHANNELS-1:0]              Ready_In;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]   Data_Out;
   logic                                 Sel_Error_Out;

   modport master (
      output Enable_In, Broadcast_In, Valid_In, Data_In, Select_In, Ready_In,
      input  Ready_Out, Valid_Out, Data_Out, Sel_Error_Out
   );

   modport slave (
      input  Enable_In, Broadcast_In, Valid_In, Data_In, Select_In, Ready_In,
      output Ready_Out, Valid_Out, Data_Out, Sel_Error_Out
   );

endinterface

// File: rtl/stream_demux_1_n_slot.sv
// One-entry register slice for a single output channel.
// Its data register only changes on a load, so a stalled word is stable.
module stream_demux_slot
   import stream_demux_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clock_In,
   input  logic                  Reset_In,
   input  logic                  Load_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   output logic                  Valid_Out,
   input  logic                  Ready_In,
   output logic [DATA_WIDTH-1:0] Data_Out,
   output logic                  Free_Out
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;

   // A load wins over a drain, which is what lets the slot carry one word per cycle
   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (Load_In) begin
         r_valid <= 1'b1;
         r_data  <= Data_In;
      end else if (Ready_In) begin
         r_valid <= 1'b0;
      end
   end

   assign Free_Out  = !r_valid | Ready_In;
   assign Valid_Out = r_valid;
   assign Data_Out  = r_data;

endmodule

// File: rtl/stream_demux_1_n.sv
// Registered 1:N stream demultiplexer with unicast, all-or-nothing broadcast and
// illegal-select detection; each channel is buffered by its own one-entry slot.
module stream_demux_1_n
   import stream_demux_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 8
) (
   input  logic             Clock_In,
   input  logic             Reset_In,
   stream_demux_1_n_if.slave bus
);

   localparam int SEL_WIDTH = sel_width(NUM_CHANNELS);

   if (NUM_CHANNELS < 2 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_channels
      $error("stream_demux_1_n: NUM_CHANNELS out of range");
   end

   logic [NUM_CHANNELS-1:0]            w_sel_hit;
   logic [NUM_CHANNELS-1:0]            w_free;
   logic [NUM_CHANNELS-1:0]            w_load;
   logic [NUM_CHANNELS-1:0]            w_valid;
   logic [DATA_WIDTH-1:0]              w_slot_data [NUM_CHANNELS];
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] w_data_flat;
   logic                               w_sel_legal;
   logic                               w_all_free;
   logic                               w_sel_free;
   logic                               w_ready;
   logic                               w_accept;
   logic                               r_sel_err;

   // One-hot select decode; an out-of-range select matches no channel
   always_comb begin
      w_sel_hit = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         w_sel_hit[k] = (bus.Select_In == SEL_WIDTH'(k));
      end
   end

   assign w_sel_legal = |w_sel_hit;
   assign w_all_free  = &w_free;
   assign w_sel_free  = |(w_sel_hit & w_free);

   // An illegal unicast is always accepted so the producer cannot deadlock on it
   assign w_ready  = bus.Enable_In &
                     (bus.Broadcast_In ? w_all_free
                                       : (w_sel_legal ? w_sel_free : 1'b1));
   assign w_accept = bus.Valid_In & w_ready;

   assign w_load = w_accept ? (bus.Broadcast_In ? {NUM_CHANNELS{1'b1}} : w_sel_hit)
                            : {NUM_CHANNELS{1'b0}};

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= w_accept & !bus.Broadcast_In & !w_sel_legal;
      end
   end

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_slot
      stream_demux_slot #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .Clock_In  (Clock_In),
         .Reset_In  (Reset_In),
         .Load_In   (w_load[k]),
         .Data_In   (bus.Data_In),
         .Valid_Out (w_valid[k]),
         .Ready_In  (bus.Ready_In[k]),
         .Data_Out  (w_slot_data[k]),
         .Free_Out  (w_free[k])
      );
   end

   always_comb begin
      w_data_flat = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         w_data_flat[k*DATA_WIDTH +: DATA_WIDTH] = w_slot_data[k];
      end
   end

   assign bus.Ready_Out     = w_ready;
   assign bus.Valid_Out     = w_valid;
   assign bus.Data_Out      = w_data_flat;
   assign bus.Sel_Error_Out = r_sel_err;

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Bench for stream_demux_1_n: an 8-channel instance for the main traffic and a
// 6-channel instance for the illegal-select case, both checked by queue scoreboards.
module tb_stream_demux_1_n;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stream_demux_1_n_if #(.DATA_WIDTH(8), .NUM_CHANNELS(8)) if8 ();
   stream_demux_1_n_if #(.DATA_WIDTH(8), .NUM_CHANNELS(6)) if6 ();

   stream_demux_1_n #(.DATA_WIDTH(8), .NUM_CHANNELS(8)) u_dut8 (
      .Clock_In (clk),
      .Reset_In (rst),
      .bus      (if8.slave)
   );

   stream_demux_1_n #(.DATA_WIDTH(8), .NUM_CHANNELS(6)) u_dut6 (
      .Clock_In (clk),
      .Reset_In (rst),
      .bus      (if6.slave)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp8_q [8][$];
   logic [7:0] exp6_q [6][$];
   logic       exp_err8 = 1'b0;
   logic       exp_err6 = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic v, input logic bc, input logic [2:0] sel, input logic [7:0] d);
      if8.Valid_In     = v;
      if8.Broadcast_In = bc;
      if8.Select_In    = sel;
      if8.Data_In      = d;
   endtask

   task automatic drive6(input logic v, input logic bc, input logic [2:0] sel, input logic [7:0] d);
      if6.Valid_In     = v;
      if6.Broadcast_In = bc;
      if6.Select_In    = sel;
      if6.Data_In      = d;
   endtask

   // Scoreboard for the 8-channel instance
   always @(negedge clk) begin
      if (rst) begin
         exp_err8 = 1'b0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (if8.Valid_Out[k] && if8.Ready_In[k]) begin
               if (exp8_q[k].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL ch8_%0d_unexpected: got 0x%0h, expected no word", k, if8.Data_Out[k*8 +: 8]);
               end else begin
                  check($sformatf("ch8_%0d_data", k), 64'(if8.Data_Out[k*8 +: 8]), 64'(exp8_q[k].pop_front()));
               end
            end
         end
         check("sel_err8", 64'(if8.Sel_Error_Out), 64'(exp_err8));
         exp_err8 = 1'b0;
         if (if8.Valid_In && if8.Ready_Out) begin
            if (if8.Broadcast_In) begin
               for (int k = 0; k < 8; k++) exp8_q[k].push_back(if8.Data_In);
            end else if (int'(if8.Select_In) < 8) begin
               exp8_q[if8.Select_In].push_back(if8.Data_In);
            end else begin
               exp_err8 = 1'b1;
            end
         end
      end
   end

   // Scoreboard for the 6-channel instance
   always @(negedge clk) begin
      if (rst) begin
         exp_err6 = 1'b0;
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (if6.Valid_Out[k] && if6.Ready_In[k]) begin
               if (exp6_q[k].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL ch6_%0d_unexpected: got 0x%0h, expected no word", k, if6.Data_Out[k*8 +: 8]);
               end else begin
                  check($sformatf("ch6_%0d_data", k), 64'(if6.Data_Out[k*8 +: 8]), 64'(exp6_q[k].pop_front()));
               end
            end
         end
         check("sel_err6", 64'(if6.Sel_Error_Out), 64'(exp_err6));
         exp_err6 = 1'b0;
         if (if6.Valid_In && if6.Ready_Out) begin
            if (if6.Broadcast_In) begin
               for (int k = 0; k < 6; k++) exp6_q[k].push_back(if6.Data_In);
            end else if (int'(if6.Select_In) < 6) begin
               exp6_q[if6.Select_In].push_back(if6.Data_In);
            end else begin
               exp_err6 = 1'b1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      if8.Enable_In = 1'b1;
      if8.Ready_In  = '0;
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      if6.Enable_In = 1'b1;
      if6.Ready_In  = '0;
      drive6(1'b0, 1'b0, 3'd0, 8'h00);
      repeat (2) cyc();
      rst = 1'b0;
      check("rst_valid", 64'(if8.Valid_Out), 64'h0);
      check("rst_data", if8.Data_Out, 64'h0);
      check("rst_err", 64'(if8.Sel_Error_Out), 64'h0);

      // Fill every slot, then reset while a broadcast would also drain+reload
      drive8(1'b1, 1'b1, 3'd0, 8'h77);
      cyc();
      check("t1_full_valid", 64'(if8.Valid_Out), 64'hFF);
      check("t1_full_data", if8.Data_Out, 64'h7777_7777_7777_7777);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) exp8_q[k].delete();
      if8.Ready_In = 8'hFF;
      drive8(1'b1, 1'b1, 3'd0, 8'h11);
      cyc();
      check("t1_rst_valid", 64'(if8.Valid_Out), 64'h0);
      check("t1_rst_data", if8.Data_Out, 64'h0);
      check("t1_rst_err", 64'(if8.Sel_Error_Out), 64'h0);
      rst = 1'b0;
      if8.Ready_In = '0;
      drive8(1'b0, 1'b0, 3'd0, 8'h00);

      // Unicast, stall, then drain and reload in one cycle
      drive8(1'b1, 1'b0, 3'd3, 8'hA5);
      @(negedge clk);
      check("t2_ready_first", 64'(if8.Ready_Out), 64'h1);
      cyc();
      check("t2_valid", 64'(if8.Valid_Out), 64'h08);
      check("t2_data", 64'(if8.Data_Out[3*8 +: 8]), 64'hA5);
      drive8(1'b1, 1'b0, 3'd3, 8'h5A);
      @(negedge clk);
      check("t2_ready_full", 64'(if8.Ready_Out), 64'h0);
      cyc();
      check("t2_hold_valid", 64'(if8.Valid_Out), 64'h08);
      check("t2_hold_data", 64'(if8.Data_Out[3*8 +: 8]), 64'hA5);
      if8.Ready_In = 8'h08;
      @(negedge clk);
      check("t2_ready_drain", 64'(if8.Ready_Out), 64'h1);
      cyc();
      check("t2_reload_valid", 64'(if8.Valid_Out), 64'h08);
      check("t2_reload_data", 64'(if8.Data_Out[3*8 +: 8]), 64'h5A);
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      cyc();
      check("t2_empty", 64'(if8.Valid_Out), 64'h0);
      if8.Ready_In = '0;

      // Back-to-back stream to channel 5
      if8.Ready_In = 8'h20;
      for (int i = 0; i < 16; i++) begin
         drive8(1'b1, 1'b0, 3'd5, 8'(i));
         cyc();
         check($sformatf("t3_word_%0d", i), {55'd0, if8.Valid_Out[5], if8.Data_Out[5*8 +: 8]}, {55'd0, 1'b1, 8'(i)});
      end
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      cyc();
      check("t3_empty", 64'(if8.Valid_Out), 64'h0);
      if8.Ready_In = '0;

      // Broadcast blocked by one stalled channel, then released
      drive8(1'b1, 1'b0, 3'd2, 8'h42);
      cyc();
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      check("t4_ch2_valid", 64'(if8.Valid_Out), 64'h04);
      drive8(1'b1, 1'b1, 3'd0, 8'h3C);
      @(negedge clk);
      check("t4_ready_blocked", 64'(if8.Ready_Out), 64'h0);
      cyc();
      check("t4_no_partial_valid", 64'(if8.Valid_Out), 64'h04);
      check("t4_no_partial_data", if8.Data_Out, 64'h0000_0F00_5A42_0000);
      if8.Ready_In = 8'h04;
      @(negedge clk);
      check("t4_ready_released", 64'(if8.Ready_Out), 64'h1);
      cyc();
      check("t4_bcast_valid", 64'(if8.Valid_Out), 64'hFF);
      check("t4_bcast_data", if8.Data_Out, 64'h3C3C_3C3C_3C3C_3C3C);
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      if8.Ready_In = 8'hFF;
      cyc();
      check("t4_empty", 64'(if8.Valid_Out), 64'h0);
      if8.Ready_In = '0;

      // Enable low blocks accepts but not draining
      drive8(1'b1, 1'b0, 3'd1, 8'h99);
      cyc();
      check("t6_ch1_valid", 64'(if8.Valid_Out), 64'h02);
      if8.Enable_In = 1'b0;
      drive8(1'b1, 1'b0, 3'd1, 8'h66);
      if8.Ready_In = 8'h02;
      @(negedge clk);
      check("t6_ready_disabled", 64'(if8.Ready_Out), 64'h0);
      cyc();
      check("t6_drained", 64'(if8.Valid_Out), 64'h0);
      check("t6_data_kept", 64'(if8.Data_Out[1*8 +: 8]), 64'h99);
      if8.Enable_In = 1'b1;
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      if8.Ready_In = '0;

      // Stalled channel does not block unicast elsewhere
      drive8(1'b1, 1'b0, 3'd0, 8'hC3);
      cyc();
      drive8(1'b1, 1'b0, 3'd4, 8'h4D);
      @(negedge clk);
      check("t7_ready_other", 64'(if8.Ready_Out), 64'h1);
      cyc();
      check("t7_valid", 64'(if8.Valid_Out), 64'h11);
      drive8(1'b0, 1'b0, 3'd0, 8'h00);
      if8.Ready_In = 8'hFF;
      cyc();
      check("t7_empty", 64'(if8.Valid_Out), 64'h0);
      if8.Ready_In = '0;

      // Illegal select on the 6-channel instance
      drive6(1'b1, 1'b0, 3'd2, 8'h21);
      cyc();
      drive6(1'b1, 1'b0, 3'd7, 8'hEE);
      @(negedge clk);
      check("t5_ready_illegal", 64'(if6.Ready_Out), 64'h1);
      cyc();
      check("t5_err_pulse", 64'(if6.Sel_Error_Out), 64'h1);
      check("t5_valid_kept", 64'(if6.Valid_Out), 64'h04);
      drive6(1'b0, 1'b0, 3'd0, 8'h00);
      cyc();
      check("t5_err_cleared", 64'(if6.Sel_Error_Out), 64'h0);
      check("t5_valid_still", 64'(if6.Valid_Out), 64'h04);
      check("t5_data_kept", if6.Data_Out, 64'h0000_0000_0021_0000);
      if6.Ready_In = 6'h04;
      cyc();
      check("t5_empty", 64'(if6.Valid_Out), 64'h0);
      if6.Ready_In = '0;

      repeat (2) cyc();
      for (int k = 0; k < 8; k++) check($sformatf("left8_%0d", k), 64'(exp8_q[k].size()), 64'h0);
      for (int k = 0; k < 6; k++) check($sformatf("left6_%0d", k), 64'(exp6_q[k].size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
